tdm_channel_mux: RTL and testbench



---
 rtl/tdm_pkg.sv | 13 +
 rtl/tdm_dwell_timer.sv | 30 +++
 rtl/tdm_channel_mux.sv | 90 +++++++++
 tb/tb_tdm_channel_mux.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM select+data link (mux and demux sides).
package tdm_pkg;

  localparam int TDM_N_CH  = 4;
  localparam int TDM_DWELL = 4;

  typedef enum logic {IDLE, SCAN} state_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/tdm_dwell_timer.sv
// Counts DWELL cycles while enabled; tc marks the last cycle of each dwell.
module tdm_dwell_timer
  import tdm_pkg::*;
#(
  parameter int DWELL = TDM_DWELL
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_reg;

  // With DWELL=1 the counter stays at 0 and tc follows en every cycle.
  assign tc = en && (cnt_reg == CW'(DWELL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_reg <= '0;
    else if (clr || tc)
      cnt_reg <= '0;
    else if (en)
      cnt_reg <= cnt_reg + 1'b1;
  end

endmodule

// File: rtl/tdm_channel_mux.sv
// Transmit end of the select+data TDM link: snapshots SW per frame and scans it out.
// Build option: TDM_GRAY_SEL_EN puts the Gray code of the slot index on SEL.
module tdm_channel_mux
  import tdm_pkg::*;
#(
  parameter int N_CH  = TDM_N_CH,
  parameter int DWELL = TDM_DWELL,
  parameter int SELW  = $clog2(N_CH)
) (
  input  logic            CLOCK_50,
  input  logic            RST,
  input  logic            EN,
  input  logic [N_CH-1:0] SW,
  output logic [SELW-1:0] SEL,
  output logic            DOUT,
  output logic            VALID,
  output logic            FRAME,
  output logic            BUSY
);

  state_t          state_reg;
  logic [N_CH-1:0] snap_reg;
  logic [SELW-1:0] slot_reg;
  logic [SELW-1:0] slot_inc;
  logic            scan;
  logic            tc;
  logic            last_slot;
  logic            start;

  function automatic logic [SELW-1:0] sel_code(input logic [SELW-1:0] s);
`ifdef TDM_GRAY_SEL_EN
    return SELW'(bin2gray(32'(s)));
`else
    return s;
`endif
  endfunction

  assign scan      = (state_reg == SCAN);
  assign slot_inc  = slot_reg + 1'b1;
  assign last_slot = (slot_reg == SELW'(N_CH - 1));
  // A frame starts from IDLE, or back-to-back at the end of the last slot.
  assign start     = EN && (!scan || (tc && last_slot));

  tdm_dwell_timer #(.DWELL(DWELL)) u_dwell (
    .clk (CLOCK_50),
    .rst (RST),
    .clr (!scan),
    .en  (scan),
    .tc  (tc)
  );

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      snap_reg  <= '0;
      slot_reg  <= '0;
      SEL       <= '0;
      DOUT      <= 1'b0;
      VALID     <= 1'b0;
      FRAME     <= 1'b0;
      BUSY      <= 1'b0;
    end else if (start) begin
      state_reg <= SCAN;
      snap_reg  <= SW;
      slot_reg  <= '0;
      SEL       <= sel_code('0);
      DOUT      <= SW[0];
      VALID     <= 1'b1;
      FRAME     <= 1'b1;
      BUSY      <= 1'b1;
    end else if (scan) begin
      FRAME <= 1'b0;
      if (tc) begin
        if (last_slot) begin
          state_reg <= IDLE;
          slot_reg  <= '0;
          SEL       <= '0;
          DOUT      <= 1'b0;
          VALID     <= 1'b0;
          BUSY      <= 1'b0;
        end else begin
          slot_reg <= slot_inc;
          SEL      <= sel_code(slot_inc);
          DOUT     <= snap_reg[slot_inc];
        end
      end
    end
  end

endmodule

// File: tb/tb_tdm_channel_mux.sv
// Randomized bench for tdm_channel_mux (DWELL=4 and DWELL=1 instances) against a frame-position model.
module tb_tdm_channel_mux;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [N-1:0] sw;

  logic [1:0] sel4, sel1;
  logic       dout4, valid4, frame4, busy4;
  logic       dout1, valid1, frame1, busy1;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: per instance, whether a frame is active, cycle position inside it, and its snapshot.
  bit         act[2];
  int         pos[2];
  logic [3:0] snap[2];
  int         dw[2] = '{4, 1};

  logic [1:0] prev_sel4;
  logic       prev_valid4 = 1'b0;

  always #5 clk = ~clk;

  tdm_channel_mux #(.N_CH(N), .DWELL(4)) dut4 (
    .CLOCK_50 (clk),
    .RST      (rst),
    .EN       (en),
    .SW       (sw),
    .SEL      (sel4),
    .DOUT     (dout4),
    .VALID    (valid4),
    .FRAME    (frame4),
    .BUSY     (busy4)
  );

  tdm_channel_mux #(.N_CH(N), .DWELL(1)) dut1 (
    .CLOCK_50 (clk),
    .RST      (rst),
    .EN       (en),
    .SW       (sw),
    .SEL      (sel1),
    .DOUT     (dout1),
    .VALID    (valid1),
    .FRAME    (frame1),
    .BUSY     (busy1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k]  = 1'b0;
      pos[k]  = 0;
      snap[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    if (!act[k]) begin
      if (en) begin
        act[k]  = 1'b1;
        pos[k]  = 0;
        snap[k] = sw;
      end
    end else begin
      pos[k]++;
      if (pos[k] == N * dw[k]) begin
        if (en) begin
          pos[k]  = 0;
          snap[k] = sw;
        end else begin
          act[k] = 1'b0;
        end
      end
    end
  endtask

  // Expected {SEL, DOUT, VALID, FRAME, BUSY}.
  function automatic logic [5:0] model_out(input int k);
    int slot;
    int code;
    if (!act[k]) return 6'd0;
    slot = pos[k] / dw[k];
`ifdef TDM_GRAY_SEL_EN
    code = slot ^ (slot >> 1);
`else
    code = slot;
`endif
    return {code[1:0], snap[k][slot], 1'b1, (pos[k] == 0), 1'b1};
  endfunction

  task automatic compare_all(input string tag);
    check_eq({tag, "/dwell4"}, 32'({sel4, dout4, valid4, frame4, busy4}), 32'(model_out(0)));
    check_eq({tag, "/dwell1"}, 32'({sel1, dout1, valid1, frame1, busy1}), 32'(model_out(1)));
`ifdef TDM_GRAY_SEL_EN
    if (prev_valid4 && valid4 && (sel4 != prev_sel4))
      check_eq({tag, "/gray_step"}, 32'($countones(sel4 ^ prev_sel4)), 32'd1);
`endif
    prev_sel4   = sel4;
    prev_valid4 = valid4;
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (rst) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    @(negedge clk);
    compare_all(tag);
  endtask

  // Raise RST between clock edges and check the outputs clear without an edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(tag);
    tick({tag, "_hold"});
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    sw  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all("reset");
    rst = 1'b0;

    // Single-cycle EN pulse with SW=1010: one full frame, then IDLE.
    sw = 4'b1010;
    en = 1'b1;
    tick("pulse");
    en = 1'b0;
    repeat (22) tick("pulse");
    $display("[TB] phase pulse done, %0d checks so far", tests_run);

    // Back-to-back frames; SW changes mid-frame 1.
    en = 1'b1;
    sw = 4'b1010;
    repeat (6) tick("b2b");
    sw = 4'b0110;
    repeat (42) tick("b2b");
    en = 1'b0;
    repeat (20) tick("b2b_tail");
    $display("[TB] phase back-to-back done, %0d checks so far", tests_run);

    // Async reset at slot 2, mid-dwell, then a fresh frame.
    en = 1'b1;
    sw = 4'b1111;
    repeat (10) tick("pre_rst");
    async_reset("async_rst");
    tick("restart");
    check_eq("restart_frame", 32'(frame4), 32'd1);
    check_eq("restart_sel", 32'(sel4), 32'd0);
    repeat (20) tick("restart");
    $display("[TB] phase async reset done, %0d checks so far", tests_run);

    // Randomized run with occasional async resets.
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 9) < 6);
      sw = 4'($urandom);
      if ($urandom_range(0, 99) == 0) async_reset("rand_rst");
      else tick("rand");
    end
    en = 1'b0;
    repeat (20) tick("drain");
    $display("[TB] phase random done, %0d checks so far", tests_run);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
